odometer_accum: RTL and testbench

Mileage accumulator that produces the binary `record` consumed by the mileage display path. It integrates travelled distance from a drive-enable and speed input, paced by a programmable divider on the slow `clk_bps` tick. It also maintains a resettable trip counter and flags saturation at the 8-digit display limit. It sits between the vehicle control FSM (power/drive inputs) and the 7-segment mileage display.

---
 rtl/odo_pkg.sv | 26 ++
 rtl/odo_tick_div.sv | 31 +++
 rtl/odometer_accum.sv | 95 +++++++++
 tb/tb_odometer_accum.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/odo_pkg.sv
// Shared definitions for the odometer accumulator: FSM encoding, record width,
// saturation ceiling and the saturating add used by both accumulators.
package odo_pkg;

  localparam int REC_W = 27;

  // Eight decimal digits on the mileage display.
  localparam logic [REC_W-1:0] MAX_REC = 27'd99_999_999;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } odo_state_e;

  // Add a 2-bit distance step to an accumulator, clamping at lim.
  // The sum is one bit wider so the carry out of bit REC_W-1 is never lost.
  function automatic logic [REC_W-1:0] sat_add(input logic [REC_W-1:0] acc,
                                               input logic [1:0]       step,
                                               input logic [REC_W-1:0] lim);
    logic [REC_W:0] sum;
    sum = {1'b0, acc} + {{(REC_W-1){1'b0}}, step};
    return (sum > {1'b0, lim}) ? lim : sum[REC_W-1:0];
  endfunction

endpackage

// File: rtl/odo_tick_div.sv
// Distance pacing divider: counts 0..DIV-1 while run is high and flags the
// terminal count. Any cycle with run low restarts the count from 0.
module odo_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk_bps,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam logic [7:0] TERM = 8'(DIV - 1);

  logic [7:0] div_cnt;

  // Free-running modulo-DIV count, held at 0 outside RUN.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk_bps) begin
    if (!rst_n) begin
      div_cnt <= 8'd0;
    end else if (!run || div_cnt == TERM) begin
      div_cnt <= 8'd0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  assign tick = run && (div_cnt == TERM);

endmodule

// File: rtl/odometer_accum.sv
// Mileage accumulator: power/drive FSM, divider-paced saturating record and
// trip counters, new-value strobe and sticky saturation flag.
module odometer_accum
  import odo_pkg::REC_W;
  import odo_pkg::odo_state_e;
  import odo_pkg::ST_OFF;
  import odo_pkg::ST_IDLE;
  import odo_pkg::ST_RUN;
  import odo_pkg::sat_add;
#(
  parameter int               DIV     = 4,
  parameter logic [REC_W-1:0] MAX_REC = odo_pkg::MAX_REC
) (
  input  logic             clk_bps,
  input  logic             rst_n,
  input  logic             power_now,
  input  logic             drive_en,
  input  logic [1:0]       speed,
  input  logic             trip_clr,
  output logic [REC_W-1:0] record,
  output logic [REC_W-1:0] trip,
  output logic             rec_valid,
  output logic             sat,
  output logic [1:0]       state
);

  odo_state_e       state_q;
  logic             tick;
  logic             inc;
  logic             rec_upd;
  logic [REC_W-1:0] rec_sum;
  logic [REC_W-1:0] trip_sum;
  logic [REC_W-1:0] record_nxt;
  logic [REC_W-1:0] trip_nxt;

  odo_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk_bps (clk_bps),
    .rst_n   (rst_n),
    .run     (state_q == ST_RUN),
    .tick    (tick)
  );

  // Increment decision and next accumulator values from current inputs.
  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    inc        = 1'b0;
    rec_upd    = 1'b0;
    rec_sum    = sat_add(record, speed, MAX_REC);
    trip_sum   = sat_add(trip, speed, MAX_REC);
    record_nxt = record;
    trip_nxt   = trip;

    // Gate on live inputs so a drop on the terminal count suppresses the step.
    inc     = tick && (speed != 2'd0) && drive_en && power_now;
    // A record already at the ceiling cannot change, so no update and no strobe.
    rec_upd = inc && (record != MAX_REC);

    if (rec_upd) record_nxt = rec_sum;

    // Trip clear wins over a coincident increment; record is unaffected.
    if (trip_clr)  trip_nxt = '0;
    else if (inc)  trip_nxt = trip_sum;
  end

  // FSM, accumulators, strobe and sticky flag; power loss keeps mileage.
  always_ff @(posedge clk_bps) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      record    <= '0;
      trip      <= '0;
      rec_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      if (!power_now) begin
        state_q <= ST_OFF;
      end else begin
        case (state_q)
          ST_OFF:  state_q <= ST_IDLE;
          ST_IDLE: if (drive_en)  state_q <= ST_RUN;
          ST_RUN:  if (!drive_en) state_q <= ST_IDLE;
          default: state_q <= ST_OFF;
        endcase
      end
      record    <= record_nxt;
      trip      <= trip_nxt;
      rec_valid <= rec_upd;
      sat       <= sat || (inc && (rec_sum == MAX_REC));
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_odometer_accum.sv
// Self-checking bench for odometer_accum: randomized drive cycles against a
// behavioural model, followed by the directed scenarios of the block.
module tb_odometer_accum;

  localparam int      DIV  = 4;
  localparam longint  MAXV = 99_999_999;

  logic        clk_bps = 1'b0;
  logic        rst_n;
  logic        power_now;
  logic        drive_en;
  logic [1:0]  speed;
  logic        trip_clr;
  logic [26:0] record;
  logic [26:0] trip;
  logic        rec_valid;
  logic        sat;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  // Behavioural model: state as 0/1/2, edges spent in RUN since entry,
  // mileage as plain integers clamped with min().
  int     m_state;
  int     m_phase;
  longint m_rec;
  longint m_trip;
  bit     m_valid;
  bit     m_sat;

  odometer_accum #(
    .DIV (DIV)
  ) dut (
    .clk_bps   (clk_bps),
    .rst_n     (rst_n),
    .power_now (power_now),
    .drive_en  (drive_en),
    .speed     (speed),
    .trip_clr  (trip_clr),
    .record    (record),
    .trip      (trip),
    .rec_valid (rec_valid),
    .sat       (sat),
    .state     (state)
  );

  always #5 clk_bps = ~clk_bps;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint clamp(input longint v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_edge();
    bit inc;
    int nxt;
    inc = (m_state == 2) && ((m_phase % DIV) == DIV - 1) && (speed != 0)
          && drive_en && power_now;
    if (!rst_n) begin
      m_state = 0; m_phase = 0; m_rec = 0; m_trip = 0; m_valid = 0; m_sat = 0;
    end else begin
      m_valid = 0;
      if (inc) begin
        if (clamp(m_rec + speed) == MAXV) m_sat = 1;
        if (m_rec != MAXV) begin
          m_rec   = clamp(m_rec + speed);
          m_valid = 1;
        end
        m_trip = clamp(m_trip + speed);
      end
      if (trip_clr) m_trip = 0;
      if (!power_now)                     nxt = 0;
      else if (m_state == 0)              nxt = 1;
      else if (m_state == 1 && drive_en)  nxt = 2;
      else if (m_state == 2 && !drive_en) nxt = 1;
      else                                nxt = m_state;
      m_phase = (m_state == 2 && nxt == 2) ? m_phase + 1 : 0;
      m_state = nxt;
    end
  endtask

  // One clock: model update at the edge, compare all outputs 1 ns later.
  task automatic step();
    @(posedge clk_bps);
    model_edge();
    #1;
    check("record",    32'(record),    32'(m_rec));
    check("trip",      32'(trip),      32'(m_trip));
    check("rec_valid", 32'(rec_valid), 32'(m_valid));
    check("sat",       32'(sat),       32'(m_sat));
    check("state",     32'(state),     32'(m_state));
  endtask

  // Overwrite the mileage registers across one edge outside RUN.
  task automatic preload(input longint rv, input longint tv);
    force dut.record = 27'(rv);
    force dut.trip   = 27'(tv);
    m_rec  = rv;
    m_trip = tv;
    step();
    release dut.record;
    release dut.trip;
  endtask

  initial begin
    int     pulses;
    int     first;
    longint saved;

    rst_n = 1'b0; power_now = 1'b0; drive_en = 1'b0; speed = 2'd0; trip_clr = 1'b0;
    #2;
    step();
    rst_n = 1'b1;

    // Randomized drive cycles.
    for (int i = 0; i < 2000; i++) begin
      power_now = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) drive_en = ~drive_en;
      if ($urandom_range(0, 3) == 0) speed = 2'($urandom_range(0, 3));
      trip_clr = ($urandom_range(0, 40) == 0);
      rst_n    = ($urandom_range(0, 300) != 0);
      step();
    end

    // Reset values.
    rst_n = 1'b0; power_now = 1'b1; drive_en = 1'b1; speed = 2'd3; trip_clr = 1'b0;
    step();
    check("rst_record", 32'(record), 0);
    check("rst_state",  32'(state),  0);
    check("rst_sat",    32'(sat),    0);
    rst_n = 1'b1;

    // Basic run: speed 2, increments every DIV edges after RUN entry.
    speed = 2'd2;
    step();                              // OFF -> IDLE
    step();                              // IDLE -> RUN (entry edge)
    check("run_entry_state", 32'(state), 2);
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (rec_valid) pulses++;
      check("run_record", 32'(record), 32'(2 * (k / 4)));
    end
    check("run_pulses", 32'(pulses), 4);
    check("run_trip",   32'(trip),   8);

    // Trip clear coincident with an increment.
    drive_en = 1'b0;
    step();                              // RUN -> IDLE
    preload(10, 5);
    drive_en = 1'b1; speed = 2'd1;
    step();                              // RUN entry
    for (int k = 0; k < 3; k++) step();
    trip_clr = 1'b1;
    step();
    trip_clr = 1'b0;
    check("clr_record", 32'(record), 11);
    check("clr_trip",   32'(trip),   0);

    // Power drop mid-count; divider restarts on RUN re-entry.
    step(); step();                      // div count now 2
    saved = m_rec;
    power_now = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("pwr_off_state", 32'(state), 0);
    end
    power_now = 1'b1;
    step();
    check("pwr_idle_state", 32'(state), 1);
    step();
    check("pwr_run_state",  32'(state), 2);
    check("pwr_retained",   32'(record), 32'(saved));
    first = 0;
    for (int k = 1; k <= 8 && first == 0; k++) begin
      step();
      if (record != 27'(saved)) first = k;
    end
    check("pwr_first_inc_edge", 32'(first), 4);

    // Speed zero: nothing accumulates.
    speed = 2'd0;
    saved = m_rec;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (rec_valid) pulses++;
    end
    check("spd0_record", 32'(record), 32'(saved));
    check("spd0_pulses", 32'(pulses), 0);

    // Saturation at the display limit.
    drive_en = 1'b0;
    step();
    preload(99_999_998, 0);
    drive_en = 1'b1; speed = 2'd3;
    step();                              // RUN entry
    for (int k = 0; k < 4; k++) step();
    check("sat_record", 32'(record), 32'(MAXV));
    check("sat_flag",   32'(sat),    1);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (rec_valid) pulses++;
    end
    check("sat_hold_record", 32'(record), 32'(MAXV));
    check("sat_hold_pulses", 32'(pulses), 0);
    check("sat_trip",        32'(trip),   6);

    // Reset mid-RUN with mileage and sat set.
    drive_en = 1'b0;
    step();
    preload(500, 7);
    drive_en = 1'b1;
    step(); step(); step();
    check("pre_rst_sat", 32'(sat), 1);
    rst_n = 1'b0;
    step();
    check("midrst_record", 32'(record),    0);
    check("midrst_trip",   32'(trip),      0);
    check("midrst_valid",  32'(rec_valid), 0);
    check("midrst_sat",    32'(sat),       0);
    check("midrst_state",  32'(state),     0);
    rst_n = 1'b1;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
